ct_f_spsram_arb_ctrl: RTL and testbench
=======================================

CT_F_SPSRAM_ARB_CTRL -- requirements
Module: ct_f_spsram_arb_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 12, SRAM word address width; DATA_WIDTH, default 144, SRAM word width.
REQ-002 SHALL have ports (N = 0, 1 for the req/rsp ports):
- CLK  in  1  single clock for all state; rising edge.
- RST  in  1  reset, asynchronous assert, active-high.
- init_start  in  1  pulse; re-runs the zero-fill when in RUN.
- init_busy  out  1  high while zero-fill is in progress.
- reqN_vld  in  1  request valid.
- reqN_rdy  out  1  request accepted this cycle.
- reqN_wr  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_wmask  in  DATA_WIDTH  per-bit write enable, active-high.
- rspN_vld  out  1  read data valid, one-cycle pulse.
- rspN_rdata  out  DATA_WIDTH  read data.
- A  out  ADDR_WIDTH  SRAM address.
- CEN  out  1  SRAM chip enable, active-low.
- GWEN  out  1  SRAM global write enable, active-low.
- WEN  out  DATA_WIDTH  SRAM bit write enables, active-low.
- D  out  DATA_WIDTH  SRAM write data.
- Q  in  DATA_WIDTH  SRAM read data.

Function
REQ-003 SHALL use a two-state FSM, INIT and RUN; reset enters INIT.
REQ-004 In INIT, each cycle SHALL drive CEN=0, GWEN=0, WEN=all 0, D=0, A=init counter.
REQ-005 The init counter SHALL start at 0, increment by 1 per cycle, and go to RUN the cycle after writing address 2^ADDR_WIDTH-1; INIT SHALL take exactly 2^ADDR_WIDTH cycles.
REQ-006 init_busy SHALL be high in INIT; reqN_rdy SHALL be 0 in INIT.
REQ-007 In RUN, init_start=1 SHALL re-enter INIT the next cycle with the counter cleared; a request arriving in the same cycle SHALL still be served; init_start in INIT SHALL be ignored.
REQ-008 In RUN, with one requester valid, it SHALL be granted: reqN_rdy=1 in the same cycle, combinational from reqN_vld.
REQ-009 With both valid, the grant SHALL go to the requester not granted last; the priority pointer SHALL reset to favour requester 0 and update only on a grant.
REQ-010 A grant SHALL drive CEN=0, A=reqN_addr; a write SHALL drive GWEN=0, WEN=~reqN_wmask, D=reqN_wdata; a read SHALL drive GWEN=1, WEN=all 1.
REQ-011 With no grant in RUN, outputs SHALL be CEN=1, GWEN=1, WEN=all 1, D=0, A=0.
REQ-012 A granted read SHALL produce rspN_vld=1 exactly one cycle after the grant, with rspN_rdata=Q in that cycle; writes SHALL produce no response.
REQ-013 rspN_rdata SHALL pass Q through, valid only while rspN_vld=1; responses have no backpressure.
REQ-014 Back-to-back grants SHALL sustain one access per cycle: a read then a write to the same address returns the old data.
REQ-015 At most one SRAM access SHALL occur per cycle; the ungranted requester SHALL see reqN_rdy=0 and must hold its request.

Reset
REQ-016 RST SHALL asynchronously force: FSM=INIT, init counter=0, priority pointer=requester 0, read-pending flags=0.
REQ-017 During RST, init_busy=1, rsp0_vld=rsp1_vld=0, reqN_rdy=0, CEN=1.
REQ-018 Reset during INIT or RUN SHALL drop any pending read response and restart the zero-fill from address 0.

Structure
REQ-019 ADDR_WIDTH/DATA_WIDTH defaults and the FSM state encodings (INIT=1'b0, RUN=1'b1) SHALL live in shared package ct_f_spsram_pkg.
REQ-020 The two-way round-robin arbiter SHALL be one sub-module, ct_f_rr_arb2, with ports vld[1:0], gnt[1:0] and a pointer register; everything else SHALL be inline.

Verification
REQ-021 Reset release, no requests -> init_busy high for 4096 cycles, CEN=0/GWEN=0 each cycle with A 0..4095, then RUN; a read of addr 0x123 returns 144'h0.
REQ-022 req0 writes addr 5, data all-ones, mask all-ones; next cycle req0 reads addr 5 -> rsp0_vld one cycle later, rdata all-ones.
REQ-023 req0 and req1 valid every cycle with reads -> grants alternate 0,1,0,1 starting with 0; each rspN_vld follows its grant by one cycle.
REQ-024 Addr 7 = all-ones; write 0 with wmask = low 72 bits set -> subsequent read returns upper 72 bits 1, lower 72 bits 0.
REQ-025 init_start pulsed in RUN with a concurrent req1 write to addr 9 -> write served, INIT restarts at 0, reqN_rdy=0 for 4096 cycles, then addr 9 reads 0.
REQ-026 RST asserted mid-INIT and the cycle after a read grant -> rsp_vld stays 0, outputs at reset values immediately, INIT restarts at address 0.

Source files
------------

// File: rtl/ct_f_spsram_pkg.sv
// Shared definitions for the single-port SRAM arbiter controller.
// Holds the default geometry and the controller state encodings.
package ct_f_spsram_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 144;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/ct_f_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
// The pointer only moves when a grant is issued.
module ct_f_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] vld,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = vld;
        if (vld == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // after granting requester 0 the next tie goes to requester 1, and vice versa
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (|gnt) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/ct_f_spsram_arb_ctrl.sv
// Two-requester front end for a single-port SRAM with a zero-fill phase after
// reset (or on request), and a one-cycle read response path.
module ct_f_spsram_arb_ctrl
    import ct_f_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  init_start,
    output logic                  init_busy,
    input  logic                  req0_vld,
    output logic                  req0_rdy,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    output logic                  rsp0_vld,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_vld,
    output logic                  req1_rdy,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [1:0]            rsp_vld_q;
    logic                  in_run;
    logic [1:0]            arb_vld;
    logic [1:0]            gnt;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] sel_wmask;

    assign in_run  = (state_q == ST_RUN);
    assign arb_vld = {req1_vld, req0_vld} & {2{in_run}};

    ct_f_rr_arb2 u_arb (
        .clk (CLK),
        .rst (RST),
        .vld (arb_vld),
        .gnt (gnt)
    );

    assign req0_rdy  = gnt[0];
    assign req1_rdy  = gnt[1];
    assign init_busy = ~in_run;

    assign rsp0_vld   = rsp_vld_q[0];
    assign rsp1_vld   = rsp_vld_q[1];
    assign rsp0_rdata = Q;
    assign rsp1_rdata = Q;

    always_comb begin
        sel_wr    = req0_wr;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        sel_wmask = req0_wmask;
        if (gnt[1]) begin
            sel_wr    = req1_wr;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
            sel_wmask = req1_wmask;
        end
    end

    // RST forces the idle pattern combinationally so the macro is quiet while reset is held
    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = {DATA_WIDTH{1'b1}};
        D    = '0;
        A    = '0;
        if (!RST) begin
            if (!in_run) begin
                CEN  = 1'b0;
                GWEN = 1'b0;
                WEN  = '0;
                A    = cnt_q;
            end else if (|gnt) begin
                CEN = 1'b0;
                A   = sel_addr;
                if (sel_wr) begin
                    GWEN = 1'b0;
                    WEN  = ~sel_wmask;
                    D    = sel_wdata;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            rsp_vld_q <= 2'b00;
        end else begin
            rsp_vld_q <= gnt & ~{req1_wr, req0_wr};
            if (!in_run) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_q <= ST_RUN;
                end
            end else if (init_start) begin
                state_q <= ST_INIT;
                cnt_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// Directed bench for ct_f_spsram_arb_ctrl with a behavioural single-port SRAM.
module tb_ct_f_spsram_arb_ctrl;

    localparam int AW = 12;
    localparam int DW = 144;
    localparam int DEPTH = 4096;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] ZERO = '0;
    localparam logic [DW-1:0] LO72 = {{72{1'b0}}, {72{1'b1}}};
    localparam logic [DW-1:0] HI72 = {{72{1'b1}}, {72{1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          init_start;
    logic          init_busy;
    logic          req0_vld, req0_rdy, req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_wmask;
    logic          rsp0_vld;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_vld, req1_rdy, req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_wmask;
    logic          rsp1_vld;
    logic [DW-1:0] rsp1_rdata;
    logic [AW-1:0] a;
    logic          cen, gwen;
    logic [DW-1:0] wen, d, q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ct_f_spsram_arb_ctrl dut (
        .CLK        (clk),
        .RST        (rst),
        .init_start (init_start),
        .init_busy  (init_busy),
        .req0_vld   (req0_vld),
        .req0_rdy   (req0_rdy),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_wmask (req0_wmask),
        .rsp0_vld   (rsp0_vld),
        .rsp0_rdata (rsp0_rdata),
        .req1_vld   (req1_vld),
        .req1_rdy   (req1_rdy),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_wmask (req1_wmask),
        .rsp1_vld   (rsp1_vld),
        .rsp1_rdata (rsp1_rdata),
        .A          (a),
        .CEN        (cen),
        .GWEN       (gwen),
        .WEN        (wen),
        .D          (d),
        .Q          (q)
    );

    // behavioural single-port SRAM: registered read, per-bit masked write
    logic [DW-1:0] mem [DEPTH];
    initial q = '0;
    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
            else       q <= mem[a];
        end
    end

    typedef struct {
        logic          v0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0, m0;
        logic          v1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1, m1;
        logic          e_rdy0, e_rdy1, e_cen, e_gwen;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wen, e_d;
        logic          e_rv0, e_rv1;
        logic [DW-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, m0,
        input logic v1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, m1,
        input logic e_rdy0, e_rdy1, e_cen, e_gwen, input logic [AW-1:0] e_a,
        input logic [DW-1:0] e_wen, e_d, input logic e_rv0, e_rv1, input logic [DW-1:0] e_rd);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_cen = e_cen; v.e_gwen = e_gwen;
        v.e_a = e_a; v.e_wen = e_wen; v.e_d = e_d;
        v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_rd = e_rd;
        return v;
    endfunction

    function automatic vec_t idle(input logic rv0, rv1, input logic [DW-1:0] rd);
        return mk(0,0,0,ZERO,ZERO, 0,0,0,ZERO,ZERO, 0,0,1,1,0,ONES,ZERO, rv0,rv1,rd);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // entered and left at posedge+1
    task automatic apply(input string nm, input vec_t v);
        req0_vld = v.v0; req0_wr = v.w0; req0_addr = v.a0; req0_wdata = v.d0; req0_wmask = v.m0;
        req1_vld = v.v1; req1_wr = v.w1; req1_addr = v.a1; req1_wdata = v.d1; req1_wmask = v.m1;
        @(negedge clk);
        chk({nm, ".rdy0"}, DW'(req0_rdy), DW'(v.e_rdy0));
        chk({nm, ".rdy1"}, DW'(req1_rdy), DW'(v.e_rdy1));
        chk({nm, ".cen"},  DW'(cen),      DW'(v.e_cen));
        chk({nm, ".gwen"}, DW'(gwen),     DW'(v.e_gwen));
        chk({nm, ".a"},    DW'(a),        DW'(v.e_a));
        chk({nm, ".wen"},  wen,           v.e_wen);
        if (v.e_cen || !v.e_gwen) chk({nm, ".d"}, d, v.e_d);
        chk({nm, ".rv0"},  DW'(rsp0_vld), DW'(v.e_rv0));
        chk({nm, ".rv1"},  DW'(rsp1_vld), DW'(v.e_rv1));
        if (v.e_rv0) chk({nm, ".rd0"}, rsp0_rdata, v.e_rd);
        if (v.e_rv1) chk({nm, ".rd1"}, rsp1_rdata, v.e_rd);
        @(posedge clk); #1;
    endtask

    // zero-fill walk; entered and left at posedge+1
    task automatic init_check(input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            init_start = (i == pulse_at);
            @(negedge clk);
            chk("init.busy", DW'(init_busy), DW'(1));
            chk("init.cen_gwen", DW'({cen, gwen}), DW'(0));
            chk("init.a", DW'(a), DW'(i));
            chk("init.wen", wen, ZERO);
            chk("init.d", d, ZERO);
            chk("init.rdy", DW'({req1_rdy, req0_rdy}), DW'(0));
            @(posedge clk); #1;
        end
        init_start = 1'b0;
    endtask

    vec_t vt [18];

    initial begin
        vt[0]  = mk(1,0,12'h123,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,12'h123,ONES,ZERO, 0,0,ZERO);
        vt[1]  = idle(1,0,ZERO);
        vt[2]  = mk(1,1,5,ONES,ONES, 0,0,0,ZERO,ZERO, 1,0,0,0,5,ZERO,ONES, 0,0,ZERO);
        vt[3]  = mk(1,0,5,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,0,ZERO);
        vt[4]  = idle(1,0,ONES);
        vt[5]  = mk(0,0,0,ZERO,ZERO, 1,1,7,ONES,ONES, 0,1,0,0,7,ZERO,ONES, 0,0,ZERO);
        vt[6]  = mk(1,0,5,ZERO,ZERO, 1,0,7,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,0,ZERO);
        vt[7]  = mk(1,0,5,ZERO,ZERO, 1,0,7,ZERO,ZERO, 0,1,0,1,7,ONES,ZERO, 1,0,ONES);
        vt[8]  = mk(1,0,5,ZERO,ZERO, 1,0,7,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,1,ONES);
        vt[9]  = mk(1,0,5,ZERO,ZERO, 1,0,7,ZERO,ZERO, 0,1,0,1,7,ONES,ZERO, 1,0,ONES);
        vt[10] = idle(0,1,ONES);
        vt[11] = mk(1,1,7,ZERO,LO72, 0,0,0,ZERO,ZERO, 1,0,0,0,7,HI72,ZERO, 0,0,ZERO);
        vt[12] = mk(0,0,0,ZERO,ZERO, 1,0,7,ZERO,ZERO, 0,1,0,1,7,ONES,ZERO, 0,0,ZERO);
        vt[13] = idle(0,1,HI72);
        vt[14] = mk(1,0,5,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,0,ZERO);
        vt[15] = mk(0,0,0,ZERO,ZERO, 1,1,5,ZERO,ONES, 0,1,0,0,5,ZERO,ZERO, 1,0,ONES);
        vt[16] = mk(1,0,5,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,0,ZERO);
        vt[17] = idle(1,0,ZERO);

        rst = 1'b1; init_start = 1'b0;
        req0_vld = 1'b1; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_vld = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", DW'(init_busy), DW'(1));
        chk("rst.cen", DW'(cen), DW'(1));
        chk("rst.rdy0", DW'(req0_rdy), DW'(0));
        chk("rst.rsp", DW'({rsp1_vld, rsp0_vld}), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        req0_vld = 1'b0;

        init_check(DEPTH, -1);
        @(negedge clk);
        chk("run.busy", DW'(init_busy), DW'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) apply($sformatf("v%0d", i), vt[i]);

        // init_start in RUN with concurrent req1 write; req0 loses the tie and keeps asking
        init_start = 1'b1;
        req0_vld = 1; req0_wr = 0; req0_addr = 3;
        req1_vld = 1; req1_wr = 1; req1_addr = 9; req1_wdata = ONES; req1_wmask = ONES;
        @(negedge clk);
        chk("restart.rdy1", DW'(req1_rdy), DW'(1));
        chk("restart.rdy0", DW'(req0_rdy), DW'(0));
        chk("restart.a", DW'(a), DW'(9));
        chk("restart.gwen", DW'(gwen), DW'(0));
        @(posedge clk); #1;
        chk("restart.mem9", mem[9], ONES);
        init_start = 1'b0; req1_vld = 1'b0;
        init_check(DEPTH, 100);
        apply("r9", mk(1,0,9,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,9,ONES,ZERO, 0,0,ZERO));
        apply("r9rsp", idle(1,0,ZERO));

        // reset the cycle after a read grant: the response must never appear
        apply("rr", mk(1,0,5,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,0,ZERO));
        rst = 1'b1;
        #1;
        chk("rstrd.rv0", DW'(rsp0_vld), DW'(0));
        chk("rstrd.cen", DW'(cen), DW'(1));
        chk("rstrd.busy", DW'(init_busy), DW'(1));
        chk("rstrd.rdy0", DW'(req0_rdy), DW'(0));
        @(negedge clk);
        chk("rstrd.rv0n", DW'(rsp0_vld), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // reset mid-INIT restarts the fill at address 0
        init_check(200, -1);
        rst = 1'b1;
        #1;
        chk("rstinit.cen", DW'(cen), DW'(1));
        chk("rstinit.a", DW'(a), DW'(0));
        chk("rstinit.busy", DW'(init_busy), DW'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        init_check(DEPTH, -1);
        apply("r5", mk(1,0,5,ZERO,ZERO, 0,0,0,ZERO,ZERO, 1,0,0,1,5,ONES,ZERO, 0,0,ZERO));
        apply("r5rsp", idle(1,0,ZERO));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
